// File: rtl/subleq_pkg.sv
// Shared types and constants for the SUBLEQ memory master.
// State encoding, default widths and the halt address.
package subleq_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int ADDR_W_DEF = 8;

    // Branch target that also signals halt (sliced to ADDR_W at use)
    localparam logic [31:0] HALT_ADDR = '1;

    typedef enum logic [3:0] {
        IDLE,
        F_A,
        F_B,
        F_C,
        R_MA,
        R_MB,
        CALC,
        WR,
        DONE
    } state_e;

endpackage

// File: rtl/subleq_mem_master_if.sv
// Core request/response handshake plus single-port BRAM bus.
// master = subleq_mem_master side, slave = core/BRAM side.
interface subleq_mem_master_if
    import subleq_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              start_valid;
    logic              start_ready;
    logic [ADDR_W-1:0] start_pc;

    logic              done_valid;
    logic              done_ready;
    logic [ADDR_W-1:0] next_pc;
    logic              halt;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  mem_rdata;

    modport master (
        input  start_valid,
        input  start_pc,
        input  done_ready,
        input  mem_rdata,
        output start_ready,
        output done_valid,
        output next_pc,
        output halt,
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output start_valid,
        output start_pc,
        output done_ready,
        output mem_rdata,
        input  start_ready,
        input  done_valid,
        input  next_pc,
        input  halt,
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

endinterface

// File: rtl/subleq_mem_master.sv
// Executes one SUBLEQ instruction per request over a 1-cycle-latency BRAM port.
// All outputs are registered; bus controls are computed from the next state.
module subleq_mem_master
    import subleq_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    subleq_mem_master_if.master bus
);

    state_e state_q, state_d;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] opa_q, opa_d;
    logic [ADDR_W-1:0] opb_q, opb_d;
    logic [ADDR_W-1:0] opc_q, opc_d;
    logic [WIDTH-1:0]  ma_q, ma_d;
    logic [WIDTH-1:0]  diff_q, diff_d;

    logic              start_ready_q, start_ready_d;
    logic              done_valid_q, done_valid_d;
    logic [ADDR_W-1:0] next_pc_q, next_pc_d;
    logic              halt_q, halt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    logic leq;

    // Operand words become addresses: zero-extend or truncate
    function automatic logic [ADDR_W-1:0] to_addr(input logic [WIDTH-1:0] v);
        return ADDR_W'(v);
    endfunction

    assign leq = diff_q[WIDTH-1] | (diff_q == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start_valid) state_d = F_A;
            F_A:     state_d = F_B;
            F_B:     state_d = F_C;
            F_C:     state_d = R_MA;
            R_MA:    state_d = R_MB;
            R_MB:    state_d = CALC;
            CALC:    state_d = WR;
            WR:      state_d = DONE;
            DONE:    if (bus.done_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_d      = pc_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        opc_d     = opc_q;
        ma_d      = ma_q;
        diff_d    = diff_q;
        next_pc_d = next_pc_q;
        halt_d    = halt_q;

        if (state_q == IDLE && bus.start_valid) begin
            pc_d = bus.start_pc;
        end

        // Read data lands one cycle after its address was presented
        unique case (state_q)
            F_B:  opa_d = to_addr(bus.mem_rdata);
            F_C:  opb_d = to_addr(bus.mem_rdata);
            R_MA: opc_d = to_addr(bus.mem_rdata);
            R_MB: ma_d  = bus.mem_rdata;
            CALC: diff_d = bus.mem_rdata - ma_q;
            WR: begin
                next_pc_d = leq ? opc_q : pc_q + ADDR_W'(3);
                halt_d    = leq && (opc_q == HALT_ADDR[ADDR_W-1:0]);
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_addr_d    = mem_addr_q;
        mem_en_d      = state_d inside {F_A, F_B, F_C, R_MA, R_MB, WR};
        mem_we_d      = (state_d == WR);
        start_ready_d = (state_d == IDLE);
        done_valid_d  = (state_d == DONE);

        case (state_d)
            F_A:     mem_addr_d = pc_d;
            F_B:     mem_addr_d = pc_q + ADDR_W'(1);
            F_C:     mem_addr_d = pc_q + ADDR_W'(2);
            R_MA:    mem_addr_d = opa_q;
            R_MB:    mem_addr_d = opb_q;
            WR:      mem_addr_d = opb_q;
            default: mem_addr_d = mem_addr_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= '0;
            opa_q         <= '0;
            opb_q         <= '0;
            opc_q         <= '0;
            ma_q          <= '0;
            diff_q        <= '0;
            start_ready_q <= 1'b1;
            done_valid_q  <= 1'b0;
            next_pc_q     <= '0;
            halt_q        <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
            opc_q         <= opc_d;
            ma_q          <= ma_d;
            diff_q        <= diff_d;
            start_ready_q <= start_ready_d;
            done_valid_q  <= done_valid_d;
            next_pc_q     <= next_pc_d;
            halt_q        <= halt_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
        end
    end

    assign bus.start_ready = start_ready_q;
    assign bus.done_valid  = done_valid_q;
    assign bus.next_pc     = next_pc_q;
    assign bus.halt        = halt_q;
    assign bus.mem_en      = mem_en_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = diff_q;

endmodule

// File: tb/tb_subleq_mem_master.sv
// Bench for subleq_mem_master: BRAM model, SUBLEQ reference model,
// directed corner cases and randomized instructions.
module tb_subleq_mem_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    subleq_mem_master_if #(.WIDTH(8), .ADDR_W(8)) bus ();

    subleq_mem_master #(.WIDTH(8), .ADDR_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] mem [256];
    logic [7:0] img [256];
    logic       load_en = 1'b0;

    // Single-port BRAM, registered read; img is copied in on load_en
    always @(posedge clk) begin
        if (load_en) begin
            mem <= img;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    // Bus activity log: {we, addr, wdata-if-write}
    logic [16:0] trace_q [$];
    always @(negedge clk) begin
        if (bus.mem_en)
            trace_q.push_back({bus.mem_we, bus.mem_addr,
                               bus.mem_we ? bus.mem_wdata : 8'h00});
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_img();
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
    endtask

    task automatic run_instr(input string tag, input logic [7:0] pc,
                             input int hold, input bit use_exp,
                             input logic [7:0] er, input logic [7:0] enpc,
                             input logic eh);
        logic [7:0]  a, b, c, r, npc;
        logic        lq, hlt;
        logic [16:0] exp_tr [6];
        int          lat, base, nd;

        a   = img[pc];
        b   = img[pc + 8'd1];
        c   = img[pc + 8'd2];
        r   = img[b] - img[a];
        lq  = r[7] || (r == 8'h00);
        npc = lq ? c : pc + 8'd3;
        hlt = lq && (c == 8'hFF);
        exp_tr[0] = {1'b0, pc, 8'h00};
        exp_tr[1] = {1'b0, pc + 8'd1, 8'h00};
        exp_tr[2] = {1'b0, pc + 8'd2, 8'h00};
        exp_tr[3] = {1'b0, a, 8'h00};
        exp_tr[4] = {1'b0, b, 8'h00};
        exp_tr[5] = {1'b1, b, r};

        lat = 0;
        while (!bus.start_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".ready"}, bus.start_ready, 1);

        base = trace_q.size();
        bus.start_valid = 1'b1;
        bus.start_pc    = pc;
        @(negedge clk);
        bus.start_valid = 1'b0;
        chk({tag, ".busy"}, bus.start_ready, 0);

        lat = 1;
        while (!bus.done_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, lat, 8);
        chk({tag, ".next_pc"}, bus.next_pc, npc);
        chk({tag, ".halt"}, bus.halt, hlt);
        if (use_exp) begin
            chk({tag, ".next_pc_ref"}, bus.next_pc, enpc);
            chk({tag, ".halt_ref"}, bus.halt, eh);
        end

        chk({tag, ".n_access"}, trace_q.size() - base, 6);
        for (int i = 0; i < 6; i++) begin
            if (base + i < trace_q.size())
                chk({tag, ".access"}, trace_q[base + i], exp_tr[i]);
        end

        bus.start_valid = (hold > 0);
        bus.start_pc    = pc + 8'd7;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ".hold_valid"}, bus.done_valid, 1);
            chk({tag, ".hold_pc"}, bus.next_pc, npc);
            chk({tag, ".hold_halt"}, bus.halt, hlt);
            chk({tag, ".hold_en"}, bus.mem_en, 0);
            chk({tag, ".hold_ready"}, bus.start_ready, 0);
        end

        bus.done_ready = 1'b1;
        @(negedge clk);
        bus.done_ready = 1'b0;
        chk({tag, ".released"}, bus.done_valid, 0);
        chk({tag, ".idle"}, bus.start_ready, 1);
        chk({tag, ".idle_en"}, bus.mem_en, 0);
        bus.start_valid = 1'b0;

        img[b] = r;
        nd = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== img[i]) nd++;
        chk({tag, ".mem_diffs"}, nd, 0);
        if (use_exp) chk({tag, ".mem_b"}, mem[b], er);
    endtask

    initial begin
        logic [7:0] pc;
        int base, nw;

        bus.start_valid = 1'b0;
        bus.start_pc    = 8'h00;
        bus.done_ready  = 1'b0;
        clear_img();
        rst_n = 1'b0;
        load_img();
        repeat (2) @(negedge clk);
        chk("rst.start_ready", bus.start_ready, 1);
        chk("rst.done_valid", bus.done_valid, 0);
        chk("rst.halt", bus.halt, 0);
        chk("rst.next_pc", bus.next_pc, 0);
        chk("rst.mem_en", bus.mem_en, 0);
        chk("rst.mem_we", bus.mem_we, 0);
        chk("rst.mem_addr", bus.mem_addr, 0);
        chk("rst.mem_wdata", bus.mem_wdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        clear_img();
        img[0] = 8'd10; img[1] = 8'd11; img[2] = 8'd6;
        img[10] = 8'd3; img[11] = 8'd5;
        load_img();
        run_instr("t1_basic", 8'h00, 0, 1, 8'd2, 8'd3, 1'b0);

        img[11] = 8'd3;
        load_img();
        run_instr("t2_zero", 8'h00, 1, 1, 8'd0, 8'd6, 1'b0);

        img[11] = 8'd1;
        load_img();
        run_instr("t2_neg", 8'h00, 0, 1, 8'hFE, 8'd6, 1'b0);

        img[10] = 8'd1; img[11] = 8'h80;
        load_img();
        run_instr("t3_ovf", 8'h00, 2, 1, 8'h7F, 8'd3, 1'b0);

        clear_img();
        img[8'hFE] = 8'd20; img[8'hFF] = 8'd21; img[0] = 8'h40;
        img[20] = 8'd1; img[21] = 8'd9;
        load_img();
        run_instr("t4_wrap", 8'hFE, 0, 1, 8'd8, 8'h01, 1'b0);

        clear_img();
        img[0] = 8'd10; img[1] = 8'd10; img[2] = 8'hFF; img[10] = 8'd7;
        load_img();
        run_instr("t5_halt", 8'h00, 3, 1, 8'd0, 8'hFF, 1'b1);

        // Reset while reading mem[B]: the write must never happen
        clear_img();
        img[0] = 8'd10; img[1] = 8'd11; img[2] = 8'd6;
        img[10] = 8'd3; img[11] = 8'd5;
        load_img();
        base = trace_q.size();
        bus.start_valid = 1'b1;
        bus.start_pc    = 8'h00;
        @(negedge clk);
        bus.start_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_rmb.en", bus.mem_en, 1);
        chk("t6_rmb.addr", bus.mem_addr, 11);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst.mem_en", bus.mem_en, 0);
        chk("t6_rst.mem_we", bus.mem_we, 0);
        chk("t6_rst.start_ready", bus.start_ready, 1);
        chk("t6_rst.done_valid", bus.done_valid, 0);
        chk("t6_rst.next_pc", bus.next_pc, 0);
        chk("t6_rst.halt", bus.halt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        nw = 0;
        for (int i = base; i < trace_q.size(); i++) if (trace_q[i][16]) nw++;
        chk("t6_rst.writes", nw, 0);
        chk("t6_rst.mem_b", mem[11], 5);
        chk("t6_rst.idle", bus.done_valid, 0);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
            load_img();
            pc = 8'($urandom);
            run_instr($sformatf("rnd%0d", n), pc, $urandom_range(0, 3),
                      0, 8'h00, 8'h00, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
